// File: rtl/edit_fifo.sv
// -----------------------------------------------------------------------------
// edit_fifo
// Synchronous FIFO with an "edit" port: besides normal write/read it can
// delete (backspace) the most recently written unread word, or replace that
// word in place when delete and write are asserted together.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          asynchronous active-low reset (release synchronised outside)
//   we           write request, data taken from data_in
//   re           read request, data_out updated one cycle later
//   del          delete / replace the newest unread word
//   clr          synchronous flush of contents and error flags
//   data_in      write data
//   data_out     registered read data, held between reads
//   rvalid       one-cycle pulse: data_out was updated by a read
//   empty, full, almost_full   occupancy flags (from registered pointers)
//   count        words stored, 0..DEPTH
//   ovf, udf     sticky overflow / underflow flags, cleared by clr or reset
// -----------------------------------------------------------------------------
module edit_fifo #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 8,
    parameter int AFULL_TH = (1 << ADDR_W) - 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              del,
    input  logic              clr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    // Storage: no reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]   w_ptr_reg, w_ptr_next;
    logic [ADDR_W:0]   r_ptr_reg, r_ptr_next;
    logic              ovf_reg, ovf_next;
    logic              udf_reg, udf_next;
    logic              rvalid_reg;
    logic [DATA_W-1:0] data_out_reg;

    logic              rd_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W:0]   w_last;

    assign count       = w_ptr_reg - r_ptr_reg;
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_CNT);
    assign almost_full = (count >= AFULL_CNT);
    assign w_last      = w_ptr_reg - PTR_ONE;

    // Next-state decision, all taken on the pre-edge state.
    // Priority: clr, then del (only meaningful when something is stored),
    // then the ordinary write/read pair. A read accompanying del needs at
    // least two words, otherwise the only word is being deleted/replaced and
    // the read is silently dropped (no underflow). When del finds the FIFO
    // empty it is ignored and any we/re behave as plain requests.
    always_comb begin
        w_ptr_next = w_ptr_reg;
        r_ptr_next = r_ptr_reg;
        ovf_next   = ovf_reg;
        udf_next   = udf_reg;
        rd_en      = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = w_ptr_reg[ADDR_W-1:0];

        if (clr) begin
            w_ptr_next = '0;
            r_ptr_next = '0;
            ovf_next   = 1'b0;
            udf_next   = 1'b0;
        end else if (del && !empty) begin
            if (we) begin
                // Replace-last: overwrite the newest word, pointer unchanged.
                mem_we    = 1'b1;
                mem_waddr = w_last[ADDR_W-1:0];
            end else begin
                w_ptr_next = w_last;
            end
            if (re && (count > PTR_ONE)) begin
                rd_en      = 1'b1;
                r_ptr_next = r_ptr_reg + PTR_ONE;
            end
        end else begin
            if (re) begin
                if (empty) begin
                    udf_next = 1'b1;
                end else begin
                    rd_en      = 1'b1;
                    r_ptr_next = r_ptr_reg + PTR_ONE;
                end
            end
            if (we) begin
                // A full FIFO drops the write even if a read frees a slot
                // this same cycle.
                if (full) begin
                    ovf_next = 1'b1;
                end else begin
                    mem_we     = 1'b1;
                    w_ptr_next = w_ptr_reg + PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr_reg    <= '0;
            r_ptr_reg    <= '0;
            ovf_reg      <= 1'b0;
            udf_reg      <= 1'b0;
            rvalid_reg   <= 1'b0;
            data_out_reg <= '0;
        end else begin
            w_ptr_reg  <= w_ptr_next;
            r_ptr_reg  <= r_ptr_next;
            ovf_reg    <= ovf_next;
            udf_reg    <= udf_next;
            rvalid_reg <= rd_en;
            if (rd_en) begin
                data_out_reg <= mem[r_ptr_reg[ADDR_W-1:0]];
            end
        end
    end

    // A read and a write never target the same address in one cycle: a read
    // only happens when at least one (two, with del) words are stored, so the
    // read slot is always older than the write slot.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            mem[mem_waddr] <= data_in;
        end
    end

    assign data_out = data_out_reg;
    assign rvalid   = rvalid_reg;
    assign ovf      = ovf_reg;
    assign udf      = udf_reg;

endmodule

// File: tb/tb_edit_fifo.sv
module tb_edit_fifo;

    localparam int DEPTH = 256;
    localparam int AF_TH = DEPTH - 4;

    logic       clk;
    logic       rst;
    logic       we, re, del, clr;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       rvalid, empty, full, almost_full, ovf, udf;
    logic [8:0] count;

    int checks;
    int errors;

    // Reference model: plain queue of stored words plus output state.
    int         q[$];
    logic [3:0] m_dout;
    logic       m_rv, m_ovf, m_udf;

    edit_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .re          (re),
        .del         (del),
        .clr         (clr),
        .data_in     (data_in),
        .data_out    (data_out),
        .rvalid      (rvalid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .ovf         (ovf),
        .udf         (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of requests, update the model from its pre-edge
    // contents, then return #1 after the edge with inputs idle.
    task automatic cycle(input logic w, input logic r, input logic dl,
                         input logic c, input logic [3:0] d);
        int pre;
        we = w; re = r; del = dl; clr = c; data_in = d;
        @(posedge clk);
        pre  = q.size();
        m_rv = 1'b0;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (dl && pre > 0) begin
            if (w) q[pre-1] = int'(d);
            else   void'(q.pop_back());
            if (r && pre >= 2) begin
                m_dout = 4'(q.pop_front());
                m_rv   = 1'b1;
            end
        end else begin
            if (r) begin
                if (pre == 0) m_udf = 1'b1;
                else begin
                    m_dout = 4'(q.pop_front());
                    m_rv   = 1'b1;
                end
            end
            if (w) begin
                if (pre == DEPTH) m_ovf = 1'b1;
                else q.push_back(int'(d));
            end
        end
        #1;
        we = 1'b0; re = 1'b0; del = 1'b0; clr = 1'b0; data_in = 4'h0;
        $display("txn t=%0t we=%0b re=%0b del=%0b clr=%0b din=%h -> count=%0d dout=%h rvalid=%0b ovf=%0b udf=%0b",
                 $time, w, r, dl, c, d, count, data_out, rvalid, ovf, udf);
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 4'h0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        we = 1'b0; re = 1'b0; del = 1'b0; clr = 1'b0; data_in = 4'h0;
        model_reset();
        #23;
        checks++;
        if ({data_out, rvalid, empty, full, almost_full, ovf, udf} !== {4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: got dout=%h rv=%0b e=%0b f=%0b af=%0b ovf=%0b udf=%0b, expected 0 0 1 0 0 0 0",
                     data_out, rvalid, empty, full, almost_full, ovf, udf);
        end
        checks++;
        if (count !== 9'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        cycle(1, 0, 0, 0, 4'd1);
        cycle(1, 0, 0, 0, 4'd2);
        cycle(1, 0, 0, 0, 4'd3);
        for (int i = 1; i <= 3; i++) begin
            cycle(0, 1, 0, 0, 4'h0);
            checks++;
            if (data_out !== 4'(i) || rvalid !== 1'b1) begin
                errors++;
                $display("FAIL basic_read%0d: got dout=%h rv=%0b expected %h 1", i, data_out, rvalid, 4'(i));
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 9'd0) begin
            errors++;
            $display("FAIL basic_empty: got empty=%0b count=%0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_delete();
        cycle(1, 0, 0, 0, 4'hA);
        cycle(1, 0, 0, 0, 4'hB);
        cycle(0, 0, 1, 0, 4'h0);
        checks++;
        if (count !== 9'd1) begin
            errors++;
            $display("FAIL delete_count: got %0d expected 1", count);
        end
        cycle(1, 0, 0, 0, 4'hC);
        cycle(0, 1, 0, 0, 4'h0);
        checks++;
        if (data_out !== 4'hA || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL delete_read1: got %h rv=%0b expected a 1", data_out, rvalid);
        end
        cycle(0, 1, 0, 0, 4'h0);
        checks++;
        if (data_out !== 4'hC || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL delete_read2: got %h rv=%0b expected c 1", data_out, rvalid);
        end
    endtask

    task automatic test_replace();
        cycle(1, 0, 0, 0, 4'hA);
        cycle(1, 0, 0, 0, 4'hB);
        cycle(1, 0, 1, 0, 4'hD);
        checks++;
        if (count !== 9'd2) begin
            errors++;
            $display("FAIL replace_count: got %0d expected 2", count);
        end
        cycle(0, 1, 0, 0, 4'h0);
        checks++;
        if (data_out !== 4'hA) begin
            errors++;
            $display("FAIL replace_read1: got %h expected a", data_out);
        end
        cycle(0, 1, 0, 0, 4'h0);
        checks++;
        if (data_out !== 4'hD || count !== 9'd0) begin
            errors++;
            $display("FAIL replace_read2: got dout=%h count=%0d expected d 0", data_out, count);
        end
    endtask

    task automatic test_del_empty();
        cycle(0, 0, 0, 1, 4'h0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 4'h0);
        checks++;
        if (count !== 9'd0 || empty !== 1'b1 || udf !== 1'b0) begin
            errors++;
            $display("FAIL del_empty: got count=%0d empty=%0b udf=%0b expected 0 1 0", count, empty, udf);
        end
        cycle(1, 0, 0, 0, 4'd5);
        cycle(0, 1, 0, 0, 4'h0);
        checks++;
        if (data_out !== 4'd5 || rvalid !== 1'b1 || udf !== 1'b0 || count !== 9'd0) begin
            errors++;
            $display("FAIL del_empty_read: got dout=%h rv=%0b udf=%0b count=%0d expected 5 1 0 0",
                     data_out, rvalid, udf, count);
        end
    endtask

    task automatic test_fill();
        cycle(0, 0, 0, 1, 4'h0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 0, 0, 4'(i % 16));
            if (i == AF_TH - 2 || i == AF_TH - 1) begin
                checks++;
                if (almost_full !== (i == AF_TH - 1)) begin
                    errors++;
                    $display("FAIL fill_afull: count=%0d got almost_full=%0b", count, almost_full);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || count !== 9'd256 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got full=%0b count=%0d ovf=%0b expected 1 256 0", full, count, ovf);
        end
        cycle(1, 0, 0, 0, 4'h7);
        checks++;
        if (ovf !== 1'b1 || count !== 9'd256) begin
            errors++;
            $display("FAIL fill_ovf: got ovf=%0b count=%0d expected 1 256", ovf, count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0, 0, 4'h0);
            checks++;
            if (data_out !== 4'(i % 16) || rvalid !== 1'b1) begin
                errors++;
                $display("FAIL fill_read%0d: got %h rv=%0b expected %h 1", i, data_out, rvalid, 4'(i % 16));
            end
        end
        cycle(0, 1, 0, 0, 4'h0);
        checks++;
        if (udf !== 1'b1 || rvalid !== 1'b0 || empty !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL fill_udf: got udf=%0b rv=%0b empty=%0b ovf=%0b expected 1 0 1 1", udf, rvalid, empty, ovf);
        end
        cycle(0, 0, 0, 1, 4'h0);
        checks++;
        if (ovf !== 1'b0 || udf !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL fill_clr: got ovf=%0b udf=%0b empty=%0b expected 0 0 1", ovf, udf, empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 4'(i + 3));
        cycle(0, 1, 0, 0, 4'h0);
        we = 1'b1; re = 1'b1; data_in = 4'h9;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (count !== 9'd0 || empty !== 1'b1 || data_out !== 4'h0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d empty=%0b dout=%h rv=%0b expected 0 1 0 0",
                     count, empty, data_out, rvalid);
        end
        we = 1'b0; re = 1'b0; data_in = 4'h0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 0, 0, 0, 4'd7);
        cycle(0, 1, 0, 0, 4'h0);
        checks++;
        if (data_out !== 4'd7 || rvalid !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_read: got dout=%h rv=%0b empty=%0b expected 7 1 1", data_out, rvalid, empty);
        end
    endtask

    task automatic test_random();
        logic w, r, dl, c;
        logic [3:0] d;
        for (int n = 0; n < 800; n++) begin
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            dl = ($urandom_range(0, 99) < 15);
            c  = ($urandom_range(0, 199) < 3);
            d  = 4'($urandom_range(0, 15));
            cycle(w, r, dl, c, d);
            checks++;
            if (count !== 9'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)
                || almost_full !== (q.size() >= AF_TH)) begin
                errors++;
                $display("FAIL rand_occ n=%0d: got count=%0d e=%0b f=%0b af=%0b expected count=%0d",
                         n, count, empty, full, almost_full, q.size());
            end
            checks++;
            if (data_out !== m_dout || rvalid !== m_rv || ovf !== m_ovf || udf !== m_udf) begin
                errors++;
                $display("FAIL rand_out n=%0d: got dout=%h rv=%0b ovf=%0b udf=%0b expected %h %0b %0b %0b",
                         n, data_out, rvalid, ovf, udf, m_dout, m_rv, m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_delete();
        test_replace();
        test_del_empty();
        test_fill();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edit_fifo.md
EDIT_FIFO -- requirements
Module: edit_fifo

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 4, meaning the word width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 8, meaning log2 of depth (DEPTH = 2^ADDR_W = 256).
REQ-003 The block SHALL provide parameter AFULL_TH, default DEPTH-4, meaning the almost_full threshold in words.
REQ-004 One clock; reset is asynchronous and active-low. Ports are named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 we  input  1  write request.
REQ-008 re  input  1  read request.
REQ-009 del  input  1  delete (backspace) the most recently written unread word.
REQ-010 clr  input  1  synchronous flush of contents and error flags.
REQ-011 data_in  input  DATA_W  write data.
REQ-012 data_out  output  DATA_W  registered read data, held between reads.
REQ-013 rvalid  output  1  one-cycle pulse: data_out updated by a read this cycle.
REQ-014 empty, full, almost_full  output  1 each  occupancy flags.
REQ-015 count  output  ADDR_W+1  words stored, 0..DEPTH.
REQ-016 ovf, udf  output  1 each  sticky overflow and underflow error flags.

Function
REQ-017 Read and write pointers SHALL be ADDR_W+1 bits wide, with the MSB as the wrap bit; the RAM SHALL be indexed by the low ADDR_W bits; pointers SHALL wrap modulo 2^(ADDR_W+1).
REQ-018 count SHALL equal w_ptr - r_ptr (mod 2^(ADDR_W+1)); empty = (count==0); full = (count==DEPTH); almost_full = (count>=AFULL_TH); all are combinational from the registered pointers.
REQ-019 Per-cycle priority SHALL be clr > del > {we, re}; the applicable case is evaluated on the pre-edge state.
REQ-020 clr: r_ptr=w_ptr=0, ovf=udf=0, rvalid=0, data_out held; we, re and del are ignored that cycle.
REQ-021 del alone, not empty: w_ptr-1; the word is discarded.
REQ-022 del when empty: no effect on pointers (the pointer SHALL never cross r_ptr) and no flag change.
REQ-023 del with we, not empty: overwrite ram[w_ptr-1] with data_in; w_ptr unchanged (replace-last).
REQ-024 del with we when empty: treated as a plain write.
REQ-025 del with re and count>=2: both apply (w_ptr-1; r_ptr+1 with read).
REQ-026 del with re and count==1: only del applies; the read is dropped and udf is not set.
REQ-027 Write (we, no del): if !full, ram[w_ptr]<=data_in and w_ptr+1; if full, the data is dropped and ovf<=1, even if re is asserted the same cycle.
REQ-028 Read (re, no dropping rule): if !empty, data_out<=ram[r_ptr], r_ptr+1, rvalid=1 next cycle (1-cycle latency); if empty, udf<=1 and data_out is held.
REQ-029 Simultaneous we and re, neither full nor empty: both execute and count is unchanged.
REQ-030 Simultaneous we and re when empty: the write succeeds, the read sets udf, and no rvalid is produced (no fall-through).
REQ-031 ovf and udf SHALL remain set until clr or reset.

Reset
REQ-032 On rst low, asynchronously: r_ptr=w_ptr=0, data_out=0, rvalid=0, ovf=udf=0; hence empty=1, full=0, almost_full=0, count=0.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 Reset asserted mid-operation SHALL discard all stored words; the first edge after release SHALL behave as from empty.
REQ-035 Reset release SHALL be synchronised externally.

Verification
REQ-036 Write 1,2,3 then read 3 times -> data_out 1,2,3 on successive cycles, each with rvalid; then empty=1, count=0.
REQ-037 Write A,B; del; write C; read twice -> outputs A,C.
REQ-038 Write A,B; del+we with data_in=D; read twice -> outputs A,D; count=0 after.
REQ-039 Empty FIFO, del for 3 cycles, then write 5 and read -> 5 read; pointers never underflow; udf=0.
REQ-040 Write 256 words (0..255 mod 16) -> full=1, almost_full set at count 252; write again -> ovf=1 and count stays 256; read all in order, wrap-around correct; read once more -> udf=1; clr -> ovf=udf=0, empty=1.
REQ-041 Write 10 words; assert rst mid-burst with we=re=1 -> immediately count=0, empty=1, data_out=0; after release, write 7 and read -> 7.
